// File: rtl/register_file_pkg.sv
// Datapath constants shared by the core, decoder and register file.
// Also provides the debug reset image in which register i holds value i.
package register_file_pkg;

  localparam int DATA_WIDTH   = 32;
  localparam int NUM_REGISTER = 32;
  localparam int ADDR_WIDTH   = $clog2(NUM_REGISTER);

  typedef logic [DATA_WIDTH-1:0]                   reg_dat_t;
  typedef logic [ADDR_WIDTH-1:0]                   reg_addr_t;
  typedef logic [NUM_REGISTER-1:0][DATA_WIDTH-1:0] regfile_t;

  function automatic regfile_t reset_image();
    regfile_t img;
    for (int i = 0; i < NUM_REGISTER; i++) begin
      img[i] = reg_dat_t'(i);
    end
    return img;
  endfunction

endpackage

// File: rtl/register_file_if.sv
// Register file bus: one writeback port (rd) and two operand read ports (rs1/rs2).
// The master drives the indices and write data; the slave returns the operands.
interface register_file_if;
  import register_file_pkg::*;

  logic      i_we;
  reg_addr_t i_rd_addr;
  reg_dat_t  i_rd;
  reg_addr_t i_rs1_addr;
  reg_addr_t i_rs2_addr;
  reg_dat_t  o_rs1;
  reg_dat_t  o_rs2;

  modport master (
    output i_we, i_rd_addr, i_rd, i_rs1_addr, i_rs2_addr,
    input  o_rs1, o_rs2
  );

  modport slave (
    input  i_we, i_rd_addr, i_rd, i_rs1_addr, i_rs2_addr,
    output o_rs1, o_rs2
  );

endinterface

// File: rtl/register_file.sv
// Integer register file: x0 reads as zero, and reset reloads the debug pattern xi = i.
// Reads are combinational (0 cycles) and writes take effect on the next edge; there is no bypass and no backpressure.
module register_file
  import register_file_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst,
  register_file_if.slave  bus
);

  regfile_t r_regs = reset_image();

  logic w_wr_en;
  assign w_wr_en = bus.i_we && (bus.i_rd_addr != '0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_regs <= reset_image();
    end else if (w_wr_en) begin
      r_regs[bus.i_rd_addr] <= bus.i_rd;
    end
  end

  // x0 is forced at the read mux, so its storage contents never reach an operand.
  assign bus.o_rs1 = (bus.i_rs1_addr == '0) ? '0 : r_regs[bus.i_rs1_addr];
  assign bus.o_rs2 = (bus.i_rs2_addr == '0) ? '0 : r_regs[bus.i_rs2_addr];

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: expected operands are queued when read addresses are driven.
// The bench pops and compares them once the combinational outputs have settled.
module tb_register_file;
  import register_file_pkg::*;

  logic i_clk = 1'b0;
  logic i_rst = 1'b0;

  register_file_if rf_if ();

  register_file dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (rf_if.slave)
  );

  always #5 i_clk = ~i_clk;

  reg_dat_t model [NUM_REGISTER];
  reg_dat_t exp_q [$];
  int n_checks = 0;
  int n_fails  = 0;

  task automatic check_eq(input string tag, input reg_dat_t obs, input reg_dat_t exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic reg_dat_t model_read(input reg_addr_t a);
    return (a == '0) ? '0 : model[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_REGISTER; i++) model[i] = reg_dat_t'(i);
  endtask

  // Drive both read indices, queue the expected values, then compare them after the outputs settle.
  task automatic read_check(input string tag, input reg_addr_t a1, input reg_addr_t a2);
    rf_if.i_rs1_addr = a1;
    rf_if.i_rs2_addr = a2;
    exp_q.push_back(model_read(a1));
    exp_q.push_back(model_read(a2));
    #1;
    check_eq({tag, "_rs1"}, rf_if.o_rs1, exp_q.pop_front());
    check_eq({tag, "_rs2"}, rf_if.o_rs2, exp_q.pop_front());
  endtask

  // One clock edge with the given controls; the model follows the register-file semantics.
  task automatic cycle(input logic rst, input logic we, input reg_addr_t addr, input reg_dat_t data);
    i_rst           = rst;
    rf_if.i_we      = we;
    rf_if.i_rd_addr = addr;
    rf_if.i_rd      = data;
    @(posedge i_clk);
    if (rst) model_reset();
    else if (we && addr != '0) model[addr] = data;
    #1;
    i_rst      = 1'b0;
    rf_if.i_we = 1'b0;
  endtask

  initial begin
    model_reset();
    rf_if.i_we       = 1'b0;
    rf_if.i_rd_addr  = '0;
    rf_if.i_rd       = '0;
    rf_if.i_rs1_addr = '0;
    rf_if.i_rs2_addr = '0;

    // Power-up contents, read before any clock edge.
    read_check("pwr_x0", 5'd0, 5'd0);
    read_check("pwr_x1x2", 5'd1, 5'd2);

    // Write x31 with all ones, reading it back on rs1 while rs2 reads x0.
    rf_if.i_rs1_addr = 5'd31;
    rf_if.i_rs2_addr = 5'd0;
    cycle(1'b0, 1'b1, 5'd31, 32'hFFFF_FFFF);
    read_check("wr_x31", 5'd31, 5'd0);
    check_eq("wr_x31_const", rf_if.o_rs1, 32'hFFFF_FFFF);

    // A write to x0 is ignored.
    cycle(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF);
    read_check("wr_x0", 5'd31, 5'd0);
    check_eq("wr_x0_const", rf_if.o_rs2, 32'h0);

    // With we=0 the register file does not change.
    cycle(1'b0, 1'b0, 5'd5, 32'h1234_5678);
    read_check("we0_x5", 5'd5, 5'd5);
    check_eq("we0_x5_const", rf_if.o_rs1, 32'h5);

    // Reset takes priority over a simultaneous write.
    cycle(1'b0, 1'b1, 5'd31, 32'hFFFF_FFFF);
    cycle(1'b1, 1'b1, 5'd3, 32'hDEAD_BEEF);
    read_check("rst_x31_x3", 5'd31, 5'd3);
    check_eq("rst_x31_const", rf_if.o_rs1, 32'h1F);
    check_eq("rst_x3_const", rf_if.o_rs2, 32'h3);

    // Read during write: the old value is visible before the edge and the new value after it.
    rf_if.i_we      = 1'b1;
    rf_if.i_rd_addr = 5'd4;
    rf_if.i_rd      = 32'hA5A5_A5A5;
    read_check("rdw_pre", 5'd4, 5'd4);
    check_eq("rdw_pre_const", rf_if.o_rs1, 32'h4);
    cycle(1'b0, 1'b1, 5'd4, 32'hA5A5_A5A5);
    read_check("rdw_post", 5'd4, 5'd4);
    check_eq("rdw_post_const", rf_if.o_rs1, 32'hA5A5_A5A5);

    // Random writes and reads with an occasional reset.
    for (int n = 0; n < 60; n++) begin
      cycle(($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 31)), reg_dat_t'($urandom()));
      read_check("rand", 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    end

    // Full sweep after a final reset.
    cycle(1'b1, 1'b0, 5'd0, 32'h0);
    for (int i = 0; i < NUM_REGISTER; i++) begin
      read_check("sweep", 5'(i), 5'(NUM_REGISTER - 1 - i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
